// File: rtl/fifo_fwft_pkg.sv
// ---------------------------------------------------------------------------
// fifo_fwft_pkg
// Shared types and helpers for the fifo_fwft block:
//   level_flags_t    : registered occupancy flags (full / almost full / almost empty)
//   decode_level()   : occupancy -> level flags for a given depth and thresholds
//   params_legal()   : elaboration-time legality check of the block parameters
// ---------------------------------------------------------------------------
package fifo_fwft_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic almost_empty;
  } level_flags_t;

  // Occupancy flags for a given word count.
  function automatic level_flags_t decode_level(
    input int unsigned count,
    input int unsigned depth,
    input int unsigned afull_th,
    input int unsigned aempty_th
  );
    level_flags_t flags;
    flags.full         = (count == depth);
    flags.almost_full  = (count >= afull_th);
    flags.almost_empty = (count <= aempty_th);
    return flags;
  endfunction

  // Thresholds must fall inside 1..DEPTH (almost full) and 0..DEPTH-1 (almost empty).
  function automatic logic params_legal(
    input int unsigned adepth,
    input int unsigned fwft,
    input int unsigned afull_th,
    input int unsigned aempty_th
  );
    int unsigned depth;
    depth = 32'd1 << adepth;
    return (adepth >= 32'd1) && (adepth <= 32'd30) && (fwft <= 32'd1) &&
           (afull_th >= 32'd1) && (afull_th <= depth) &&
           (aempty_th <= depth - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_fwft_sdpram.sv
// ---------------------------------------------------------------------------
// fifo_fwft_sdpram
// Simple dual-port RAM, DWIDTH x 2^ADEPTH, one write port and one read port
// with a 1-cycle registered read. The array itself is never cleared; only the
// read data register is reset.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset (read register)
//   i_wr_en/i_wr_addr/i_wr_data : write port
//   i_rd_en/i_rd_addr       : read request; o_rd_data valid the cycle after
//   o_rd_data               : registered read data, holds when i_rd_en=0
// ---------------------------------------------------------------------------
module fifo_fwft_sdpram #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned ADEPTH = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADEPTH-1:0] i_wr_addr,
  input  logic [DWIDTH-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADEPTH-1:0] i_rd_addr,
  output logic [DWIDTH-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 32'd1 << ADEPTH;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_rd_data;

  // Storage array write.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_fwft.sv
// ---------------------------------------------------------------------------
// fifo_fwft
// Synchronous FIFO with selectable first-word-fall-through (FWFT=1) or
// standard registered-read (FWFT=0) behaviour, built around one SDPRAM.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset (priority over flush)
//   i_flush         : synchronous clear of contents; wr/rd ignored that cycle
//   i_wr_en, i_din  : write request and data
//   o_full, o_almost_full, o_overflow : write-side status (overflow = 1-cycle pulse)
//   i_rd_en         : read request (FWFT: acknowledge of o_dout)
//   o_dout          : read data
//   o_empty, o_almost_empty, o_underflow : read-side status (underflow = 1-cycle pulse)
//   o_count         : words held, including the FWFT output stage
// ---------------------------------------------------------------------------
module fifo_fwft
  import fifo_fwft_pkg::*;
#(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned ADEPTH    = 5,
  parameter int unsigned FWFT      = 1,
  parameter int unsigned AFULL_TH  = (32'd1 << ADEPTH) - 32'd2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_wr_en,
  input  logic [DWIDTH-1:0] i_din,
  output logic              o_full,
  output logic              o_almost_full,
  output logic              o_overflow,
  input  logic              i_rd_en,
  output logic [DWIDTH-1:0] o_dout,
  output logic              o_empty,
  output logic              o_almost_empty,
  output logic              o_underflow,
  output logic [ADEPTH:0]   o_count
);

  localparam int unsigned DEPTH = 32'd1 << ADEPTH;
  localparam int unsigned PW    = ADEPTH + 1;

  if (!params_legal(ADEPTH, FWFT, AFULL_TH, AEMPTY_TH)) begin : g_param_check
    $error("fifo_fwft: illegal ADEPTH/FWFT/AFULL_TH/AEMPTY_TH combination");
  end

  // Registered state.
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_count;
  level_flags_t      r_lvl;
  logic              r_empty;
  logic              r_overflow;
  logic              r_underflow;
  logic              r_ram_vld;
  logic [DWIDTH-1:0] r_dout;

  // Next-state and control wires.
  logic [PW-1:0]     w_wr_ptr_nxt;
  logic [PW-1:0]     w_rd_ptr_nxt;
  logic [PW-1:0]     w_count_nxt;
  logic [PW-1:0]     w_ram_used;
  level_flags_t      w_lvl_nxt;
  logic              w_empty_nxt;
  logic              w_overflow_nxt;
  logic              w_underflow_nxt;
  logic              w_ram_vld_nxt;
  logic [DWIDTH-1:0] w_dout_nxt;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_load_out;
  logic              w_ram_wr;
  logic              w_ram_rd;
  logic [DWIDTH-1:0] w_ram_q;

  fifo_fwft_sdpram #(
    .DWIDTH (DWIDTH),
    .ADEPTH (ADEPTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_ram_wr && !i_rst),
    .i_wr_addr (r_wr_ptr[ADEPTH-1:0]),
    .i_wr_data (i_din),
    .i_rd_en   (w_ram_rd && !i_rst),
    .i_rd_addr (r_rd_ptr[ADEPTH-1:0]),
    .o_rd_data (w_ram_q)
  );

  // Acceptance, pointer/count update, prefetch control and flag decode.
  always_comb begin
    w_wr_acc        = i_wr_en && !r_lvl.full;
    w_rd_acc        = i_rd_en && !r_empty;
    // Words still in the RAM, not yet fetched into the read pipeline.
    w_ram_used      = r_wr_ptr - r_rd_ptr;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_count_nxt     = r_count;
    w_empty_nxt     = r_empty;
    w_overflow_nxt  = 1'b0;
    w_underflow_nxt = 1'b0;
    w_ram_vld_nxt   = r_ram_vld;
    w_dout_nxt      = r_dout;
    w_load_out      = 1'b0;
    w_ram_wr        = 1'b0;
    w_ram_rd        = 1'b0;

    if (i_flush) begin
      w_wr_ptr_nxt  = '0;
      w_rd_ptr_nxt  = '0;
      w_count_nxt   = '0;
      w_empty_nxt   = 1'b1;
      w_ram_vld_nxt = 1'b0;
      if (FWFT != 0) begin
        w_dout_nxt = '0;
      end
    end else begin
      w_overflow_nxt  = i_wr_en && r_lvl.full;
      w_underflow_nxt = i_rd_en && r_empty;
      w_ram_wr        = w_wr_acc;
      if (w_wr_acc) begin
        w_wr_ptr_nxt = r_wr_ptr + PW'(1);
      end

      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + PW'(1);
        2'b01:   w_count_nxt = r_count - PW'(1);
        default: w_count_nxt = r_count;
      endcase

      if (FWFT != 0) begin
        // Output stage refills whenever it is empty or being consumed.
        w_load_out = r_empty || w_rd_acc;
        // Keep the RAM read register full so a read never leaves a bubble.
        w_ram_rd   = (w_ram_used != '0) && (!r_ram_vld || w_load_out);
        if (w_ram_rd) begin
          w_ram_vld_nxt = 1'b1;
        end else if (w_load_out) begin
          w_ram_vld_nxt = 1'b0;
        end
        if (w_load_out) begin
          w_empty_nxt = !r_ram_vld;
          if (r_ram_vld) begin
            w_dout_nxt = w_ram_q;
          end
        end
      end else begin
        w_ram_rd    = w_rd_acc;
        w_empty_nxt = (w_count_nxt == '0);
      end

      if (w_ram_rd) begin
        w_rd_ptr_nxt = r_rd_ptr + PW'(1);
      end
    end

    // Flags follow the next count so they land in the same cycle as o_count.
    w_lvl_nxt = decode_level(32'(w_count_nxt), DEPTH, AFULL_TH, AEMPTY_TH);
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr           <= '0;
      r_rd_ptr           <= '0;
      r_count            <= '0;
      r_lvl.full         <= 1'b0;
      r_lvl.almost_full  <= 1'b0;
      r_lvl.almost_empty <= 1'b1;
      r_empty            <= 1'b1;
      r_overflow         <= 1'b0;
      r_underflow        <= 1'b0;
      r_ram_vld          <= 1'b0;
      r_dout             <= '0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_lvl       <= w_lvl_nxt;
      r_empty     <= w_empty_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
      r_ram_vld   <= w_ram_vld_nxt;
      r_dout      <= w_dout_nxt;
    end
  end

  // Standard mode reads straight from the RAM read register.
  assign o_dout         = (FWFT != 0) ? r_dout : w_ram_q;
  assign o_full         = r_lvl.full;
  assign o_almost_full  = r_lvl.almost_full;
  assign o_almost_empty = r_lvl.almost_empty;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;
  assign o_empty        = r_empty;
  assign o_count        = r_count;

endmodule
